// File: rtl/tpu_array.sv
`default_nettype none
// ============================================================================
// Module   : tpu_array
// Purpose  : NxN weight-stationary systolic matrix-vector engine. Weights are
//            loaded one row per cycle; each accepted vector d yields
//            y[j] = sum_i d[i]*W[i][j] with per-vector signed/unsigned mode,
//            optional accumulation, saturation to AW bits, and a fixed
//            2*N-cycle latency with all lanes aligned.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_array #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:N][DW-1:0]   d,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic                 in_acc,
  input  logic [1:N][DW-1:0]   w,
  input  logic [$clog2(N)-1:0] w_row,
  input  logic                 w_we,
  output logic                 w_err,
  output logic [1:N][AW-1:0]   o,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int RW = $clog2(N);
  // Column sums carry one extra bit so both modes share a signed representation
  localparam int SW = 2*DW + RW + 1;
  // Accumulate width: wide enough that acc + sum can never overflow before clamping
  localparam int XW = ((AW > SW) ? AW : SW) + 2;
  localparam logic [RW:0] N_ROWS = (RW+1)'(N);
  localparam logic signed [XW-1:0] S_MAX = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [XW-1:0] S_MIN = {{(XW-AW+1){1'b1}}, {(AW-1){1'b0}}};
  localparam logic signed [XW-1:0] U_MAX = {{(XW-AW){1'b0}}, {AW{1'b1}}};

  logic                 accept;
  logic                 row_ok;
  logic [1:N][DW-1:0]   w_mem [N];
  logic [N-1:0][DW-1:0] d_at;
  logic [N-1:0]         rv, rs, ra;
  logic signed [SW-1:0] rp [N][N];
  logic [N-1:0]         dv, ds, da;
  logic signed [SW-1:0] dp [N][N];
  logic [XW-1:0]        acc_ext [N];
  logic [XW-1:0]        sum_ext [N];
  logic signed [XW-1:0] tot [N];
  logic [1:N][AW-1:0]   sat;

  // Product of two DW-bit operands, sign-extended to the column-sum width
  function automatic logic signed [SW-1:0] mul(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic          sgn);
    logic signed [DW:0]     ax;
    logic signed [DW:0]     bx;
    logic signed [2*DW+1:0] p;
    ax = {sgn & a[DW-1], a};
    bx = {sgn & b[DW-1], b};
    p  = ax * bx;
    return SW'(p);
  endfunction

  assign in_ready = !rst && !w_we;
  assign accept   = in_valid && in_ready;
  assign row_ok   = ({1'b0, w_row} < N_ROWS);
  assign busy     = out_valid | (|rv) | (|dv);

  // Weight storage; writes are refused while vectors are in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) w_mem[i] <= '0;
      w_err <= 1'b0;
    end else begin
      w_err <= w_we && (busy || !row_ok);
      if (w_we && !busy && row_ok) w_mem[w_row] <= w;
    end
  end

  // Lane 0 meets row 0 at the accept edge; later lanes are skewed below
  assign d_at[0] = d[1];

  for (genvar i = 1; i < N; i++) begin : g_skew
    logic [DW-1:0] line [i];
    // Delay lane i by i cycles so it arrives at row i together with its partial sums
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int t = 0; t < i; t++) line[t] <= '0;
      end else begin
        line[0] <= d[i+1];
        for (int t = 1; t < i; t++) line[t] <= line[t-1];
      end
    end
    assign d_at[i] = line[i-1];
  end

  // Systolic rows: stage k adds d[k]*W[k][j] to the sums passed down from stage k-1
  always_ff @(posedge clk) begin
    if (rst) begin
      rv <= '0;
      rs <= '0;
      ra <= '0;
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++) rp[k][j] <= '0;
    end else begin
      rv[0] <= accept;
      rs[0] <= in_signed;
      ra[0] <= in_acc;
      for (int j = 0; j < N; j++) rp[0][j] <= mul(d_at[0], w_mem[0][j+1], in_signed);
      for (int k = 1; k < N; k++) begin
        rv[k] <= rv[k-1];
        rs[k] <= rs[k-1];
        ra[k] <= ra[k-1];
        for (int j = 0; j < N; j++)
          rp[k][j] <= rp[k-1][j] + mul(d_at[k], w_mem[k][j+1], rs[k-1]);
      end
    end
  end

  // Delay line padding the pipeline to exactly 2*N cycles from accept to output
  always_ff @(posedge clk) begin
    if (rst) begin
      dv <= '0;
      ds <= '0;
      da <= '0;
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++) dp[k][j] <= '0;
    end else begin
      dv[0] <= rv[N-1];
      ds[0] <= rs[N-1];
      da[0] <= ra[N-1];
      for (int j = 0; j < N; j++) dp[0][j] <= rp[N-1][j];
      for (int k = 1; k < N; k++) begin
        dv[k] <= dv[k-1];
        ds[k] <= ds[k-1];
        da[k] <= da[k-1];
        for (int j = 0; j < N; j++) dp[k][j] <= dp[k-1][j];
      end
    end
  end

  // Accumulate (acc read in the vector's own mode) and clamp to the AW range
  always_comb begin
    sat = '0;
    for (int j = 0; j < N; j++) begin
      acc_ext[j] = ds[N-1] ? {{(XW-AW){o[j+1][AW-1]}}, o[j+1]}
                           : {{(XW-AW){1'b0}}, o[j+1]};
      sum_ext[j] = {{(XW-SW){dp[N-1][j][SW-1]}}, dp[N-1][j]};
      tot[j]     = (da[N-1] ? acc_ext[j] : '0) + sum_ext[j];
      if (ds[N-1]) begin
        if (tot[j] > S_MAX)      sat[j+1] = S_MAX[AW-1:0];
        else if (tot[j] < S_MIN) sat[j+1] = S_MIN[AW-1:0];
        else                     sat[j+1] = tot[j][AW-1:0];
      end else begin
        if (tot[j][XW-1])        sat[j+1] = '0;
        else if (tot[j] > U_MAX) sat[j+1] = U_MAX[AW-1:0];
        else                     sat[j+1] = tot[j][AW-1:0];
      end
    end
  end

  // Output/accumulator register; o holds until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
    end else begin
      out_valid <= dv[N-1];
      if (dv[N-1]) o <= sat;
    end
  end

endmodule
`default_nettype wire

// File: doc/tpu_array.md
Name: tpu_array

Overview:
- Parametrised successor to the fixed 4-lane tpu: an NxN weight-stationary systolic matrix-vector engine.
- Stores an NxN weight matrix W, loaded one row per cycle.
- Accepts one input vector d[1..N] per cycle and returns y[j] = sum over i of d[i]*W[i][j] for j = 1..N.
- Adds over the old block: per-vector signed/unsigned mode, optional accumulation across vectors, saturation, and a valid/ready handshake with fixed, deskewed latency.

Parameters:
N, 4, array dimension (lanes, rows, columns); N >= 2
DW, 8, data and weight width
AW, 24, output/accumulator width; AW >= 2*DW

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
d  in  [1:N] x DW  input vector
in_valid  in  1  d, in_signed and in_acc are valid this cycle
in_ready  out  1  vector accepted when in_valid && in_ready
in_signed  in  1  1: d, W and result are two's complement; 0: unsigned
in_acc  in  1  1: add result to running accumulator; 0: overwrite it
w  in  [1:N] x DW  one weight row, W[w_row][1..N]
w_row  in  clog2(N)  row index, 0-based
w_we  in  1  weight row write strobe
w_err  out  1  one-cycle pulse: weight write rejected
o  out  [1:N] x AW  result vector
out_valid  out  1  o valid, one cycle per accepted vector
busy  out  1  at least one accepted vector has not yet produced out_valid

Behaviour:
- Reset:
  - On rst=1 at a clock edge, all weights, pipeline registers, accumulators and o clear to 0.
  - out_valid=0, w_err=0 and busy=0 from the next cycle.
  - A reset mid-operation discards all in-flight vectors; no out_valid is produced for them.
  - in_ready is 0 while rst=1.
- in_ready:
  - in_ready = !rst && !w_we (combinational).
  - Fully pipelined: one vector may be accepted every cycle.
- Weight write:
  - w_we=1 with busy=0: row w_row is written at the edge and is used by vectors accepted from the next cycle onward.
  - w_we=1 with busy=1: write ignored, weights unchanged, w_err=1 for exactly the next cycle.
  - w_row >= N: write ignored, w_err pulses.
  - w_we has priority over in_valid in the same cycle: the vector is not accepted because in_ready=0.
- Latency:
  - out_valid is asserted exactly 2*N cycles after the accept edge.
  - All N lanes of o are aligned in that same cycle; deskew is internal.
  - Vectors accepted on consecutive cycles produce out_valid on consecutive cycles, in order.
- Arithmetic:
  - Products are 2*DW bits, signed or unsigned per the vector's in_signed.
  - Mode bits travel with their vector, so mixed-mode back-to-back vectors are legal.
  - Column sums are formed at full precision (2*DW + clog2(N) bits).
- Accumulation:
  - in_acc=0: acc[j] = sum.
  - in_acc=1: acc[j] = acc[j] + sum.
  - The result saturates to the AW range of the vector's mode:
    - signed: [-2^(AW-1), 2^(AW-1)-1]
    - unsigned: [0, 2^AW-1]
  - Saturation applies in both acc and non-acc modes.
  - o[j] = acc[j], held stable until the next out_valid.
- busy:
  - Set on the accept edge.
  - Cleared after the last in-flight vector's out_valid cycle.
  - Simultaneous accept and final output keep busy=1.

Test Plan:
- N=4, W all ones, d = 1,2,3,4, unsigned, in_acc=0 -> after 8 cycles: out_valid for 1 cycle, o = 10,10,10,10.
- W = identity, 5 back-to-back vectors d = k,2k,3k,4k for k = 1..5 -> 5 consecutive out_valid cycles, o = d of each vector in order; in_ready held 1.
- W all 2, d all 8'hFF:
  - signed -> o all 24'hFFFFF8 (-8)
  - unsigned -> o all 2040
  - sent back-to-back, each result matches its own mode.
- in_acc: three vectors d all 1, W all ones, in_acc = 0,1,1 -> o = 4, then 8, then 12.
- Saturation: instance AW=16, unsigned, d and W all 8'hFF -> o all 16'hFFFF. Signed, d all 8'h80, W all 8'h80, with in_acc=1 repeated -> o saturates at 16'h7FFF, no wrap.
- Control corner cases:
  - w_we issued while busy -> w_err pulses 1 cycle, results unchanged.
  - w_we with in_valid in the same cycle -> vector not accepted.
  - rst asserted 3 cycles after an accept -> no out_valid, busy=0, and o=0 from the next cycle.
